rs_issue_sched: RTL
===================

# rs_issue_sched

Issue and allocation scheduler for one reservation-station bank of `rs_buf` entries.
- Allocation: assigns free entries to up to three incoming instruction lanes per cycle by driving each entry's `newRsSelect`.
- Issue: picks one ready entry per functional-unit port (AGU, ALU1, ALU2) with per-port round-robin fairness, driving each entry's `outRsSelect`.
- Sits between rename/dispatch and the entry array; it owns no operand data, only selection state.

## Interface
Parameters:
- ENTRIES, 8, number of `rs_buf` entries in the bank (power of two, 4..16)
- PORTS, 3, issue ports: 0=AGU, 1=ALU1, 2=ALU2
- LANES, 3, dispatch lanes per cycle

Ports:
- clk  in  1  clock (one clock domain)
- rst  in  1  reset, asynchronous, active-high
- stall  in  1  freezes allocation and issue
- entryFree  in  ENTRIES  `bufFree` of each entry
- entryReady  in  PORTS*ENTRIES  `portReady` of entry e for port p at bit p*ENTRIES+e
- newValid  in  LANES  lane l carries an instruction needing an entry
- newRsSelect  out  LANES*ENTRIES  one-hot entry for lane l at bits l*ENTRIES+:ENTRIES; combinational
- allocStall  out  1  insufficient entries; dispatch must hold; combinational
- outRsSelect  out  PORTS*ENTRIES  one-hot issued entry for port p; registered
- outValid  out  PORTS  port p issued this cycle; registered

## Operation
Allocation (combinational from registered state):
- avail = entryFree & ~allocPend.
- Lanes are served in index order. Each valid lane takes the lowest-index avail bit not already taken by a lower lane.
- All-or-nothing: if popcount(avail) < popcount(newValid), then allocStall=1 and all newRsSelect=0.
- If stall=1: newRsSelect=0 and allocStall=0.
- allocPend register: allocPend <= OR of the newRsSelect lanes. This covers the one-cycle lag before `bufFree` drops.

Issue (registered):
- cand[p] = entryReady[p] & ~issuedMask, where issuedMask = OR of the current outRsSelect ports. This keeps an issuing entry out until its ready flag clears.
- Ports are resolved in order 0, 1, 2; entries granted to a lower port are removed from cand of higher ports.
- Port p picks the first set bit of cand[p], scanning upward from ptr[p] and wrapping at ENTRIES-1 to 0.
- On a grant at index g: outRsSelect[p] <= one-hot(g), outValid[p] <= 1, ptr[p] <= (g+1) mod ENTRIES.
- No candidate: outRsSelect[p] <= 0, outValid[p] <= 0, ptr holds.
- stall=1: all outRsSelect/outValid <= 0, ptr and allocPend hold.

Reset values: outRsSelect=0, outValid=0, ptr[*]=0, allocPend=0. rst asserted mid-operation clears these immediately, with no pending grant replay.

## Timing
- Issue latency: entryReady sampled at edge t → outRsSelect valid during cycle t+1, held exactly one cycle.
- The same entry is never granted in two consecutive cycles.
- Allocation is zero-latency: newRsSelect is valid in the same cycle as newValid.
- The entry allocated at edge t is excluded from avail during cycle t+1.
- Simultaneous ready on all ports for a single entry: only port 0 gets it.
- Wrap-around: ptr = ENTRIES-1 with the only ready entry at 0 grants entry 0, and ptr becomes 1.
- Zero free entries with newValid=0: allocStall=0.

## Structure
- Package `rs_sched_pkg`:
  - localparams PORT_AGU=0, PORT_ALU1=1, PORT_ALU2=2
  - default ENTRIES
  - function `popcnt`
- Sub-module `rs_rr_pick`:
  - params W; inputs req[W], ptr[log2 W]; outputs gnt[W] one-hot, found, idx.
  - Implemented as a double-width rotate-and-find-first.
  - Instantiated once per port.
- Allocation uses a chained find-first per lane, inlined.

## Test plan
- Reset: rst=1 asynchronously mid-cycle → outValid=0, outRsSelect=0 immediately; after release, first grant from index 0.
- Round-robin: entryReady port 1 = 8'b1000_0001 held for 4 cycles → grants 0, 7, 0, 7; ptr[1] values 1, 0, 1, 0; never the same entry back-to-back.
- Port conflict: entry 3 ready on ports 0, 1, 2 only → outRsSelect port 0 = 8'h08, ports 1 and 2 outValid=0.
- Allocation: entryFree=8'b0010_1100, newValid=3'b111 → lanes get entries 2, 3, 5; next cycle, with entryFree unchanged, newValid=3'b001 → allocStall=1.
- Stall: stall=1 with ready entries → outValid=0 and newRsSelect=0 for the stall cycles; ptr unchanged; resumes with the same grant as before the stall.
- Wrap: ptr[2]=7 (after a grant at entry 6), only entry 0 ready on port 2 → grant 0, ptr[2]=1.

Source files
------------

// File: rtl/rs_sched_pkg.sv
// Shared constants and helpers for the reservation-station issue/allocation scheduler.
package rs_sched_pkg;

  localparam int PORT_AGU   = 0;
  localparam int PORT_ALU1  = 1;
  localparam int PORT_ALU2  = 2;
  localparam int RS_ENTRIES = 8;

  function automatic int unsigned popcnt(input logic [31:0] v);
    int unsigned n;
    n = 32'd0;
    for (int i = 0; i < 32; i++) begin
      n = n + {31'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/rs_rr_pick.sv
// Round-robin picker: first set request at or above ptr, wrapping to index 0.
module rs_rr_pick #(
  parameter int W  = 8,
  parameter int PW = $clog2(W)
) (
  input  logic [W-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [W-1:0]  gnt_o,
  output logic          found_o,
  output logic [PW-1:0] idx_o
);

  logic [2*W-1:0] dbl_s;
  logic [W-1:0]   rot_s;
  logic [PW-1:0]  off_s;

  // Rotate so ptr lands at bit 0, then take the lowest set bit of the rotated view.
  always_comb begin
    dbl_s   = {req_i, req_i} >> ptr_i;
    rot_s   = dbl_s[W-1:0];
    off_s   = '0;
    found_o = 1'b0;
    for (int k = W - 1; k >= 0; k--) begin
      off_s   = rot_s[k] ? PW'(k) : off_s;
      found_o = found_o | rot_s[k];
    end
    idx_o = ptr_i + off_s;
    gnt_o = found_o ? (W'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/rs_issue_sched.sv
// Allocation and per-port round-robin issue selection for one reservation-station bank.
module rs_issue_sched
  import rs_sched_pkg::*;
#(
  parameter int ENTRIES = RS_ENTRIES,
  parameter int PORTS   = 3,
  parameter int LANES   = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic [ENTRIES-1:0]         entryFree,
  input  logic [PORTS*ENTRIES-1:0]   entryReady,
  input  logic [LANES-1:0]           newValid,
  output logic [LANES*ENTRIES-1:0]   newRsSelect,
  output logic                       allocStall,
  output logic [PORTS*ENTRIES-1:0]   outRsSelect,
  output logic [PORTS-1:0]           outValid
);

  localparam int PW = $clog2(ENTRIES);

  logic [PORTS*ENTRIES-1:0] out_sel_q, out_sel_d;
  logic [PORTS-1:0]         out_valid_q, out_valid_d;
  logic [PORTS*PW-1:0]      ptr_q, ptr_d;
  logic [ENTRIES-1:0]       alloc_pend_q, alloc_pend_d;

  logic [ENTRIES-1:0]       avail_s, rem_s, issued_s;
  logic [LANES*ENTRIES-1:0] pick_s;
  logic                     enough_s;
  logic [PORTS*ENTRIES-1:0] gnt_all_s;
  logic [PORTS-1:0]         found_all_s;
  logic [PORTS*PW-1:0]      idx_all_s;

  // Chained lowest-bit allocation across lanes in index order.
  always_comb begin
    avail_s = entryFree & ~alloc_pend_q;
    rem_s   = avail_s;
    pick_s  = '0;
    for (int l = 0; l < LANES; l++) begin
      if (newValid[l]) begin
        pick_s[l*ENTRIES +: ENTRIES] = rem_s & (~rem_s + ENTRIES'(1));
        rem_s = rem_s & ~pick_s[l*ENTRIES +: ENTRIES];
      end else begin
        pick_s[l*ENTRIES +: ENTRIES] = '0;
      end
    end
  end

  assign enough_s = popcnt(32'(avail_s)) >= popcnt(32'(newValid));

  // All-or-nothing gating of the lane picks.
  always_comb begin
    newRsSelect = '0;
    allocStall  = 1'b0;
    if (stall) begin
      newRsSelect = '0;
    end else if (!enough_s) begin
      allocStall = 1'b1;
    end else begin
      newRsSelect = pick_s;
    end
  end

  // Entries currently being issued stay out until their ready flag drops.
  always_comb begin
    issued_s = '0;
    for (int p = 0; p < PORTS; p++) begin
      issued_s = issued_s | out_sel_q[p*ENTRIES +: ENTRIES];
    end
  end

  for (genvar p = 0; p < PORTS; p++) begin : g_port
    logic [ENTRIES-1:0] cand_s, gnt_s, excl_s;
    logic               found_s;
    logic [PW-1:0]      idx_s;

    if (p == PORT_AGU) begin : g_first
      assign cand_s = entryReady[p*ENTRIES +: ENTRIES] & ~issued_s;
      assign excl_s = gnt_s;
    end else begin : g_next
      assign cand_s = entryReady[p*ENTRIES +: ENTRIES] & ~issued_s & ~g_port[p-1].excl_s;
      assign excl_s = g_port[p-1].excl_s | gnt_s;
    end

    rs_rr_pick #(.W(ENTRIES), .PW(PW)) u_pick (
      .req_i   (cand_s),
      .ptr_i   (ptr_q[p*PW +: PW]),
      .gnt_o   (gnt_s),
      .found_o (found_s),
      .idx_o   (idx_s)
    );

    assign gnt_all_s[p*ENTRIES +: ENTRIES] = gnt_s;
    assign found_all_s[p]                  = found_s;
    assign idx_all_s[p*PW +: PW]           = idx_s;
  end

  // Next-state for grants, pointers and the pending-allocation mask.
  always_comb begin
    out_sel_d    = '0;
    out_valid_d  = '0;
    ptr_d        = ptr_q;
    alloc_pend_d = alloc_pend_q;
    if (!stall) begin
      out_sel_d    = gnt_all_s;
      out_valid_d  = found_all_s;
      alloc_pend_d = '0;
      for (int l = 0; l < LANES; l++) begin
        alloc_pend_d = alloc_pend_d | newRsSelect[l*ENTRIES +: ENTRIES];
      end
      for (int p = 0; p < PORTS; p++) begin
        ptr_d[p*PW +: PW] = found_all_s[p] ? (idx_all_s[p*PW +: PW] + PW'(1)) : ptr_q[p*PW +: PW];
      end
    end else begin
      out_sel_d = '0;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_sel_q    <= '0;
      out_valid_q  <= '0;
      ptr_q        <= '0;
      alloc_pend_q <= '0;
    end else begin
      out_sel_q    <= out_sel_d;
      out_valid_q  <= out_valid_d;
      ptr_q        <= ptr_d;
      alloc_pend_q <= alloc_pend_d;
    end
  end

  assign outRsSelect = out_sel_q;
  assign outValid    = out_valid_q;

endmodule
